muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller beside the execute-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and sequences a 32-iteration shift-add / restoring-divide datapath. It owns the architectural HI/LO registers and raises a pipeline stall only when a dependent instruction arrives while an operation is in flight. Independent instructions continue through the ALU.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the multiply/divide controller:
//                function-field codes, FSM state encoding, operation kinds
//                and a 32-bit magnitude helper.
//  Ports       : (package - none)
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  // Function-field codes accepted from the execute stage
  localparam logic [5:0] c_FF_MULT  = 6'h18;
  localparam logic [5:0] c_FF_MULTU = 6'h19;
  localparam logic [5:0] c_FF_DIV   = 6'h1A;
  localparam logic [5:0] c_FF_DIVU  = 6'h1B;
  localparam logic [5:0] c_FF_MTHI  = 6'h11;
  localparam logic [5:0] c_FF_MTLO  = 6'h13;

  localparam logic [4:0] c_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MUL_S = 2'd0,
    MUL_U = 2'd1,
    DIV_S = 2'd2,
    DIV_U = 2'd3
  } op_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Execute-stage <-> mul/div controller bundle.
//  Ports       : start, ff[5:0], rd_hilo, data1[31:0], data2[31:0]  (requester)
//                hi[31:0], lo[31:0], busy, done, stall          (controller)
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_if;
  logic        start;
  logic [5:0]  ff;
  logic        rd_hilo;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, ff, rd_hilo, data1, data2,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, ff, rd_hilo, data1, data2,
    output hi, lo, busy, done, stall
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the shared datapath.
//                Multiply: add multiplicand into the upper half when the
//                multiplier LSB is set, then shift {upper,lower} right.
//                Divide : shift {rem,dividend} left, trial-subtract divisor,
//                keep the difference and set the quotient bit if it fits.
//  Ports       : i_op     operation kind
//                i_hi     upper half (partial product / remainder)
//                i_lo     lower half (multiplier / dividend->quotient)
//                i_b      multiplicand / divisor
//                o_hi     next upper half, o_lo next lower half
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
(
  input  op_t         i_op,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [32:0] w_sum;
  logic [32:0] w_shifted;
  logic [31:0] w_diff;

  always_comb begin
    w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : 33'd0);
    w_shifted = {i_hi, i_lo[31]};
    // The kept remainder is always below the divisor, so the low 32 bits
    // of the difference are exact.
    w_diff    = w_shifted[31:0] - i_b;
    o_hi      = w_sum[32:1];
    o_lo      = {w_sum[0], i_lo[31:1]};
    if (i_op == DIV_S || i_op == DIV_U) begin
      if (w_shifted >= {1'b0, i_b}) begin
        o_hi = w_diff;
        o_lo = {i_lo[30:0], 1'b1};
      end else begin
        o_hi = w_shifted[31:0];
        o_lo = {i_lo[30:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//                Operations run on magnitudes for 32 iterations, then a FIX
//                cycle applies signs and writes HI/LO. MTHI/MTLO write
//                directly when idle. stall is raised only for requests that
//                arrive while an operation is in flight.
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    muldiv_if.slave (start/ff/rd_hilo/data1/data2 in,
//                       hi/lo/busy/done/stall out)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  muldiv_if.slave   bus
);

  state_t      r_state, w_next;
  op_t         r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc_hi, r_acc_lo, r_b;
  logic        r_neg_q;   // signs of operands differ
  logic        r_neg_r;   // dividend negative
  logic        r_dz;      // divide-by-zero: r_acc_lo holds the raw dividend
  logic [31:0] r_hi, r_lo;

  logic        w_accept, w_busy, w_done;
  logic [31:0] w_step_hi, w_step_lo;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_q, w_r, w_res_hi, w_res_lo;

  muldiv_step u_step (
    .i_op (r_op),
    .i_hi (r_acc_hi),
    .i_lo (r_acc_lo),
    .i_b  (r_b),
    .o_hi (w_step_hi),
    .o_lo (w_step_lo)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state / outputs ----------------
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done   = (r_state == S_DONE);
        w_accept = bus.start;
        w_next   = S_IDLE;
        if (bus.start) begin
          case (bus.ff)
            c_FF_MULT, c_FF_MULTU: w_next = S_RUN;
            c_FF_DIV, c_FF_DIVU:   w_next = (bus.data2 == 32'd0) ? S_FIX : S_RUN;
            default:               w_next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 5'd0) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- sign fix-up and result select ----------------
  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_prod_s = (r_op == MUL_S && r_neg_q) ? (~w_prod + 64'd1) : w_prod;
    w_q      = (r_op == DIV_S && r_neg_q) ? (~r_acc_lo + 32'd1) : r_acc_lo;
    w_r      = (r_op == DIV_S && r_neg_r) ? (~r_acc_hi + 32'd1) : r_acc_hi;
    if (r_dz) begin
      w_res_hi = r_acc_lo;
      w_res_lo = 32'hFFFF_FFFF;
    end else if (r_op == DIV_S || r_op == DIV_U) begin
      w_res_hi = w_r;
      w_res_lo = w_q;
    end else begin
      w_res_hi = w_prod_s[63:32];
      w_res_lo = w_prod_s[31:0];
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= MUL_U;
      r_cnt    <= 5'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_b      <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            case (bus.ff)
              c_FF_MULT, c_FF_MULTU, c_FF_DIV, c_FF_DIVU: begin
                r_cnt    <= c_LAST_ITER;
                r_acc_hi <= 32'd0;
                r_dz     <= (bus.ff == c_FF_DIV || bus.ff == c_FF_DIVU)
                            && (bus.data2 == 32'd0);
                r_neg_q  <= bus.data1[31] ^ bus.data2[31];
                r_neg_r  <= bus.data1[31];
                case (bus.ff)
                  // Multiplier sits in the low half, multiplicand in r_b.
                  c_FF_MULT: begin
                    r_op     <= MUL_S;
                    r_acc_lo <= abs32(bus.data2);
                    r_b      <= abs32(bus.data1);
                  end
                  c_FF_MULTU: begin
                    r_op     <= MUL_U;
                    r_acc_lo <= bus.data2;
                    r_b      <= bus.data1;
                  end
                  // Dividend sits in the low half; on a zero divisor the raw
                  // dividend is kept there so FIX can return it in HI.
                  c_FF_DIV: begin
                    r_op     <= DIV_S;
                    r_acc_lo <= (bus.data2 == 32'd0) ? bus.data1 : abs32(bus.data1);
                    r_b      <= abs32(bus.data2);
                  end
                  default: begin
                    r_op     <= DIV_U;
                    r_acc_lo <= bus.data1;
                    r_b      <= bus.data2;
                  end
                endcase
              end
              c_FF_MTHI: r_hi <= bus.data1;
              c_FF_MTLO: r_lo <= bus.data1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.stall = w_busy & (bus.start | bus.rd_hilo);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_ctrl
//  Description : Directed self-checking bench for muldiv_ctrl. Inputs change
//                1 time unit after the rising edge; outputs are sampled there.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   edges;
  int   busy_cyc;
  bit   overlap;

  muldiv_if bus ();

  muldiv_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one sampling edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.ff    = f;
    bus.data1 = a;
    bus.data2 = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called just after the start edge. Returns the number of further edges
  // until done is visible (done is then sampled at the edge after that),
  // the number of busy cycles, and whether done and busy ever coincided.
  task automatic wait_done(output int n_edges, output int n_busy, output bit both);
    n_edges = 0;
    n_busy  = bus.busy ? 1 : 0;
    both    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_edges++;
      if (bus.done && bus.busy) both = 1'b1;
      if (bus.done) return;
      if (bus.busy) n_busy++;
    end
    n_edges = -1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.ff      = 6'h00;
    bus.rd_hilo = 1'b0;
    bus.data1   = 32'd0;
    bus.data2   = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_hi",    bus.hi,    32'd0);
    chk("rst_lo",    bus.lo,    32'd0);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_done",  bus.done,  1'b0);
    chk("rst_stall", bus.stall, 1'b0);

    // MULTU max x max, plus latency: HI/LO written at edge 33, done visible
    // after edge 33 (sampled at edge 34), busy after edges 0..32.
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy_edge0", bus.busy, 1'b1);
    wait_done(edges, busy_cyc, overlap);
    chk("multu_done_edges", edges, 33);
    chk("multu_busy_cycles", busy_cyc, 33);
    chk("multu_no_overlap", overlap, 1'b0);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    tick();
    chk("multu_done_pulse", bus.done, 1'b0);

    // MULT -3 x 7 with stall behaviour while in RUN
    issue(6'h18, 32'hFFFF_FFFD, 32'd7);
    repeat (5) tick();
    bus.rd_hilo = 1'b1;
    #1;
    chk("run_rdhilo_stall", bus.stall, 1'b1);
    bus.rd_hilo = 1'b0;
    bus.start   = 1'b1;
    bus.ff      = 6'h19;
    bus.data1   = 32'd2;
    bus.data2   = 32'd2;
    #1;
    chk("run_start_stall", bus.stall, 1'b1);
    tick();
    tick();
    chk("run_start_stall_held", bus.stall, 1'b1);
    chk("run_hi_unchanged", bus.hi, 32'hFFFF_FFFE);
    bus.start = 1'b0;
    #1;
    chk("run_idle_req_nostall", bus.stall, 1'b0);
    wait_done(edges, busy_cyc, overlap);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);

    // DIV -7 / 2
    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_done(edges, busy_cyc, overlap);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    // MFHI in the DONE cycle sees the new value without stalling
    bus.rd_hilo = 1'b1;
    #1;
    chk("done_rdhilo_stall", bus.stall, 1'b0);
    chk("done_rdhilo_hi", bus.hi, 32'hFFFF_FFFF);
    bus.rd_hilo = 1'b0;

    // Back-to-back: DIVU 7 / 2 accepted in the DONE cycle
    issue(6'h1B, 32'd7, 32'd2);
    chk("b2b_busy", bus.busy, 1'b1);
    chk("b2b_done_low", bus.done, 1'b0);
    wait_done(edges, busy_cyc, overlap);
    chk("divu_lo", bus.lo, 32'd3);
    chk("divu_hi", bus.hi, 32'd1);

    // Divide by zero: FIX straight after the start edge
    issue(6'h1A, 32'h1234_5678, 32'd0);
    wait_done(edges, busy_cyc, overlap);
    chk("dz_done_edges", edges, 1);
    chk("dz_hi", bus.hi, 32'h1234_5678);
    chk("dz_lo", bus.lo, 32'hFFFF_FFFF);

    // Most-negative / -1
    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(edges, busy_cyc, overlap);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);
    tick();

    // MTHI / MTLO in IDLE, then an unrecognized code
    issue(6'h11, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    chk("mthi_no_done", bus.done, 1'b0);
    chk("mthi_no_busy", bus.busy, 1'b0);
    issue(6'h13, 32'h5A5A_5A5A, 32'd0);
    chk("mtlo_lo", bus.lo, 32'h5A5A_5A5A);
    chk("mtlo_hi_kept", bus.hi, 32'hA5A5_A5A5);
    chk("mtlo_no_done", bus.done, 1'b0);
    issue(6'h20, 32'h0000_0000, 32'h0000_0000);
    chk("unk_hi", bus.hi, 32'hA5A5_A5A5);
    chk("unk_lo", bus.lo, 32'h5A5A_5A5A);
    chk("unk_busy", bus.busy, 1'b0);

    // Reset sampled at iteration 10 of a DIV
    issue(6'h1A, 32'd100, 32'd3);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    issue(6'h19, 32'd3, 32'd5);
    wait_done(edges, busy_cyc, overlap);
    chk("post_rst_edges", edges, 33);
    chk("post_rst_lo", bus.lo, 32'd15);
    chk("post_rst_hi", bus.hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
